// File: rtl/score_display.sv
// Two-player BCD scoreboard with multiplexed 7-segment scan and win detection.
// Optional winner blink is built only when SCORE_DISPLAY_BLINK_EN is defined.
module score_display #(
   parameter int  DIGITS      = 1,
   parameter int  REFRESH_DIV = 100000,
   parameter int  WIN_SCORE   = 9,
   parameter int  BLINK_DIV   = 25000000,
   localparam int NAN         = 2*DIGITS+2
) (
   input  logic           clk_100MHz,
   input  logic           reset,
   input  logic           score_a,
   input  logic           score_b,
   input  logic           clear,
   output logic [NAN-1:0] an,
   output logic [7:0]     seg,
   output logic           game_over,
   output logic           winner
);
   localparam int SW = 4*DIGITS;
   localparam int PW = $clog2(REFRESH_DIV);
   localparam int IW = $clog2(NAN);
   localparam logic [7:0] SEG_DASH  = 8'b11111101;
   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] SEG_ZERO  = 8'b00000011;

   if (DIGITS < 1 || DIGITS > 2 || REFRESH_DIV < 2 || BLINK_DIV < 1 || WIN_SCORE < 1) begin : g_param_check
      $error("score_display: illegal parameter set");
   end

   function automatic logic [SW-1:0] to_bcd(input int v);
      logic [SW-1:0] r;
      int            rem;
      r   = '0;
      rem = v;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(rem % 10);
         rem         = rem / 10;
      end
      return r;
   endfunction

   function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
      logic [SW-1:0] r;
      logic          cy;
      r  = v;
      cy = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (cy) begin
            if (r[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = r[4*i +: 4] + 4'd1;
               cy          = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [7:0] seg_of(input logic [3:0] d);
      case (d)
         4'd0:    seg_of = 8'b00000011;
         4'd1:    seg_of = 8'b10011111;
         4'd2:    seg_of = 8'b00100101;
         4'd3:    seg_of = 8'b00001101;
         4'd4:    seg_of = 8'b10011001;
         4'd5:    seg_of = 8'b01001001;
         4'd6:    seg_of = 8'b01000001;
         4'd7:    seg_of = 8'b00011111;
         4'd8:    seg_of = 8'b00000001;
         4'd9:    seg_of = 8'b00001001;
         default: seg_of = SEG_BLANK;
      endcase
   endfunction

   localparam logic [SW-1:0] WIN_BCD = to_bcd(WIN_SCORE);

   logic [SW-1:0]  score_a_q, score_a_d, score_b_q, score_b_d;
   logic           hist_a_q, hist_a_d, hist_b_q, hist_b_d;
   logic           game_over_q, game_over_d, winner_q, winner_d;
   logic [PW-1:0]  presc_q, presc_d;
   logic [IW-1:0]  slot_q, slot_d;
   logic [NAN-1:0] an_q, an_d;
   logic [7:0]     seg_q, seg_d;
   logic           ev_a, ev_b, blank_a, blank_b;

`ifdef SCORE_DISPLAY_BLINK_EN
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic          blink_on_q, blink_on_d;

   // Free-running; a new game does not restart the blink phase.
   always_comb begin
      blink_cnt_d = blink_cnt_q + BW'(1);
      blink_on_d  = blink_on_q;
      if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
         blink_cnt_d = '0;
         blink_on_d  = ~blink_on_q;
      end
   end

   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         blink_cnt_q <= '0;
         blink_on_q  <= 1'b1;
      end else begin
         blink_cnt_q <= blink_cnt_d;
         blink_on_q  <= blink_on_d;
      end
   end
`else
   logic blink_on_d;
   assign blink_on_d = 1'b1;
`endif

   always_comb begin
      ev_a        = score_a & ~hist_a_q;
      ev_b        = score_b & ~hist_b_q;
      hist_a_d    = score_a;
      hist_b_d    = score_b;
      score_a_d   = score_a_q;
      score_b_d   = score_b_q;
      game_over_d = game_over_q;
      winner_d    = winner_q;
      if (clear) begin
         hist_a_d    = 1'b0;
         hist_b_d    = 1'b0;
         score_a_d   = '0;
         score_b_d   = '0;
         game_over_d = 1'b0;
         winner_d    = 1'b0;
      end else if (!game_over_q) begin
         // Win is judged on the registered scores; A takes a same-cycle tie.
         if (score_a_q == WIN_BCD || score_b_q == WIN_BCD) begin
            game_over_d = 1'b1;
            winner_d    = (score_a_q != WIN_BCD);
         end
         if (ev_a && score_a_q != WIN_BCD) score_a_d = bcd_inc(score_a_q);
         if (ev_b && score_b_q != WIN_BCD) score_b_d = bcd_inc(score_b_q);
      end
   end

   always_comb begin
      presc_d = presc_q + PW'(1);
      slot_d  = slot_q;
      if (presc_q == PW'(REFRESH_DIV - 1)) begin
         presc_d = '0;
         slot_d  = (slot_q == IW'(NAN - 1)) ? '0 : slot_q + IW'(1);
      end
   end

   // Display is built from next-state values so an/seg move on the slot edge.
   always_comb begin
      blank_a = game_over_d & ~winner_d & ~blink_on_d;
      blank_b = game_over_d &  winner_d & ~blink_on_d;
      an_d    = '1;
      seg_d   = SEG_DASH;
      for (int s = 0; s < NAN; s++) an_d[s] = (slot_d != IW'(s));
      for (int i = 0; i < DIGITS; i++) begin
         if (slot_d == IW'(i)) begin
            seg_d = seg_of(score_b_d[4*i +: 4]);
            if (DIGITS > 1 && i == DIGITS-1 && score_b_d[4*i +: 4] == 4'd0) seg_d = SEG_BLANK;
            if (blank_b) seg_d = SEG_BLANK;
         end
         if (slot_d == IW'(DIGITS + 2 + i)) begin
            seg_d = seg_of(score_a_d[4*i +: 4]);
            if (DIGITS > 1 && i == DIGITS-1 && score_a_d[4*i +: 4] == 4'd0) seg_d = SEG_BLANK;
            if (blank_a) seg_d = SEG_BLANK;
         end
      end
   end

   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         score_a_q   <= '0;
         score_b_q   <= '0;
         hist_a_q    <= 1'b0;
         hist_b_q    <= 1'b0;
         game_over_q <= 1'b0;
         winner_q    <= 1'b0;
         presc_q     <= '0;
         slot_q      <= '0;
         an_q        <= {{(NAN-1){1'b1}}, 1'b0};
         seg_q       <= SEG_ZERO;
      end else begin
         score_a_q   <= score_a_d;
         score_b_q   <= score_b_d;
         hist_a_q    <= hist_a_d;
         hist_b_q    <= hist_b_d;
         game_over_q <= game_over_d;
         winner_q    <= winner_d;
         presc_q     <= presc_d;
         slot_q      <= slot_d;
         an_q        <= an_d;
         seg_q       <= seg_d;
      end
   end

   assign an        = an_q;
   assign seg       = seg_q;
   assign game_over = game_over_q;
   assign winner    = winner_q;
endmodule

// File: tb/tb_score_display.sv
// Bench for score_display: two instances (1-digit and 2-digit) share stimulus
// and are checked against an integer-level scoreboard model every cycle.
module tb_score_display;
   localparam int R   = 4;
   localparam int BLK = 8;

   logic       clk = 1'b0;
   logic       rst, a, b, clr;
   logic [3:0] an1;
   logic [5:0] an2;
   logic [7:0] seg1, seg2;
   logic       go1, wn1, go2, wn2;

   score_display #(.DIGITS(1), .REFRESH_DIV(R), .WIN_SCORE(9), .BLINK_DIV(BLK)) u1 (
      .clk_100MHz(clk), .reset(rst), .score_a(a), .score_b(b), .clear(clr),
      .an(an1), .seg(seg1), .game_over(go1), .winner(wn1));

   score_display #(.DIGITS(2), .REFRESH_DIV(R), .WIN_SCORE(12), .BLINK_DIV(BLK)) u2 (
      .clk_100MHz(clk), .reset(rst), .score_a(a), .score_b(b), .clear(clr),
      .an(an2), .seg(seg2), .game_over(go2), .winner(wn2));

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   bit chk_model = 1'b0;

   logic [7:0] SEGS [10] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F, 8'h01, 8'h09};
   int WINS [2] = '{9, 12};
   int DG   [2] = '{1, 2};
   int sa [2], sb [2];
   bit go [2], wn [2];
   bit pa, pb;
   int n;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit blink_on();
`ifdef SCORE_DISPLAY_BLINK_EN
      return ((n / BLK) % 2) == 0;
`else
      return 1'b1;
`endif
   endfunction

   function automatic logic [7:0] exp_seg(input int m, input int slot);
      int d, val, idx;
      bit plyr_b;
      d = DG[m];
      if (slot >= d && slot < d+2) return 8'hFD;
      if (slot < d) begin val = sb[m]; idx = slot;       plyr_b = 1'b1; end
      else          begin val = sa[m]; idx = slot - d - 2; plyr_b = 1'b0; end
      if (go[m] && wn[m] == plyr_b && !blink_on()) return 8'hFF;
      if (idx == 1) val = val / 10;
      val = val % 10;
      if (d == 2 && idx == 1 && val == 0) return 8'hFF;
      return SEGS[val];
   endfunction

   task automatic model_edge();
      bit ea, eb;
      ea = a && !pa;
      eb = b && !pb;
      if (rst) begin
         for (int m = 0; m < 2; m++) begin sa[m] = 0; sb[m] = 0; go[m] = 0; wn[m] = 0; end
         pa = 0; pb = 0; n = 0;
      end else begin
         for (int m = 0; m < 2; m++) begin
            if (clr) begin
               sa[m] = 0; sb[m] = 0; go[m] = 0; wn[m] = 0;
            end else if (!go[m]) begin
               if (sa[m] == WINS[m] || sb[m] == WINS[m]) begin
                  go[m] = 1; wn[m] = (sa[m] != WINS[m]);
               end
               if (ea && sa[m] < WINS[m]) sa[m]++;
               if (eb && sb[m] < WINS[m]) sb[m]++;
            end
         end
         pa = clr ? 1'b0 : a;
         pb = clr ? 1'b0 : b;
         n++;
      end
   endtask

   task automatic model_check();
      for (int m = 0; m < 2; m++) begin
         int nan, slot;
         logic [31:0] ean;
         nan  = 2*DG[m] + 2;
         slot = (n / R) % nan;
         ean  = ((32'd1 << nan) - 1) & ~(32'd1 << slot);
         chk(m == 0 ? "an1" : "an2", m == 0 ? 32'(an1) : 32'(an2), ean);
         chk(m == 0 ? "seg1" : "seg2", m == 0 ? 32'(seg1) : 32'(seg2), 32'(exp_seg(m, slot)));
         chk(m == 0 ? "go1" : "go2", m == 0 ? 32'(go1) : 32'(go2), 32'(go[m]));
         if (go[m]) chk(m == 0 ? "wn1" : "wn2", m == 0 ? 32'(wn1) : 32'(wn2), 32'(wn[m]));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      if (chk_model) model_check();
   endtask

   task automatic do_reset();
      rst = 1; a = 0; b = 0; clr = 0;
      tick();
      rst = 0;
   endtask

   task automatic pulse(input bit pa_i, input bit pb_i);
      a = pa_i; b = pb_i; tick();
      a = 0; b = 0; tick();
   endtask

   typedef struct {
      bit         a, b, c;
      logic [3:0] an;
      logic [7:0] seg;
   } vec_t;
   vec_t tbl [16];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{1, 1, 0, 4'b1110, 8'h9F};
      tbl[1]  = '{0, 0, 0, 4'b1110, 8'h9F};
      tbl[2]  = '{1, 0, 0, 4'b1110, 8'h9F};
      tbl[3]  = '{0, 0, 0, 4'b1101, 8'hFD};
      tbl[4]  = '{1, 1, 0, 4'b1101, 8'hFD};
      tbl[5]  = '{0, 0, 0, 4'b1101, 8'hFD};
      tbl[6]  = '{0, 0, 0, 4'b1101, 8'hFD};
      tbl[7]  = '{0, 0, 0, 4'b1011, 8'hFD};
      tbl[8]  = '{1, 0, 0, 4'b1011, 8'hFD};
      tbl[9]  = '{1, 0, 0, 4'b1011, 8'hFD};
      tbl[10] = '{1, 0, 0, 4'b1011, 8'hFD};
      tbl[11] = '{1, 0, 0, 4'b0111, 8'h99};
      tbl[12] = '{1, 0, 1, 4'b0111, 8'h03};
      tbl[13] = '{1, 0, 0, 4'b0111, 8'h9F};
      tbl[14] = '{0, 0, 0, 4'b0111, 8'h9F};
      tbl[15] = '{0, 1, 0, 4'b1110, 8'h9F};

      // Reset state
      rst = 1; a = 0; b = 0; clr = 0;
      tick(); tick();
      chk("rst_an1", 32'(an1), 32'h0000000E);
      chk("rst_seg1", 32'(seg1), 32'h03);
      chk("rst_go1", 32'(go1), 32'd0);
      chk("rst_wn1", 32'(wn1), 32'd0);
      chk("rst_an2", 32'(an2), 32'h0000003E);
      chk("rst_seg2", 32'(seg2), 32'h03);
      rst = 0;
      chk_model = 1'b1;

      // Directed table: scan order, coincident events, held input, clear priority
      for (int k = 0; k < 16; k++) begin
         a = tbl[k].a; b = tbl[k].b; clr = tbl[k].c;
         tick();
         chk($sformatf("tbl_an[%0d]", k), 32'(an1), 32'(tbl[k].an));
         chk($sformatf("tbl_seg[%0d]", k), 32'(seg1), 32'(tbl[k].seg));
         chk($sformatf("tbl_go[%0d]", k), 32'(go1), 32'd0);
      end
      a = 0; b = 0; clr = 0;

      // Held score_a counts once
      do_reset();
      a = 1;
      for (int k = 0; k < 10; k++) tick();
      a = 0;
      begin
         bit found = 0;
         for (int k = 0; k < 20 && !found; k++) begin
            tick();
            if (an1 == 4'b0111) begin found = 1; chk("hold_a_seg", 32'(seg1), 32'h9F); end
         end
         chk("hold_a_slot3_seen", 32'(found), 32'd1);
      end

      // Two-digit game to 12 won by B; 13th pulse ignored
      do_reset();
      for (int k = 0; k < 12; k++) pulse(0, 1);
      tick(); tick();
      chk("b12_go2", 32'(go2), 32'd1);
      chk("b12_wn2", 32'(wn2), 32'd1);
      chk("b12_go1", 32'(go1), 32'd1);
      chk("b12_wn1", 32'(wn1), 32'd1);
      pulse(0, 1);
      for (int k = 0; k < 6*R; k++) begin
         tick();
         if (an2 == 6'b011111) chk("b12_a_tens_blank", 32'(seg2), 32'hFF);
         if (an2 == 6'b101111) chk("b12_a_ones", 32'(seg2), 32'h03);
`ifndef SCORE_DISPLAY_BLINK_EN
         if (an2 == 6'b111110) chk("b12_b_ones", 32'(seg2), 32'h25);
         if (an2 == 6'b111101) chk("b12_b_tens", 32'(seg2), 32'h9F);
`endif
      end

      // Tie at WIN_SCORE goes to A
      do_reset();
      for (int k = 0; k < 8; k++) pulse(1, 1);
      chk("tie_pre_go1", 32'(go1), 32'd0);
      pulse(1, 1);
      tick();
      chk("tie_go1", 32'(go1), 32'd1);
      chk("tie_wn1", 32'(wn1), 32'd0);

      // Clear beats a same-cycle event
      a = 1; clr = 1; tick();
      chk("clr_go1", 32'(go1), 32'd0);
      a = 0; clr = 0; tick();

      // Reset mid-slot
      pulse(1, 0); tick();
      rst = 1; a = 1; tick();
      chk("midrst_an1", 32'(an1), 32'h0000000E);
      chk("midrst_seg1", 32'(seg1), 32'h03);
      chk("midrst_an2", 32'(an2), 32'h0000003E);
      chk("midrst_go1", 32'(go1), 32'd0);
      rst = 0; a = 0;

      // Winner display after an A win
      do_reset();
      for (int k = 0; k < 9; k++) pulse(1, 0);
      for (int k = 0; k < 48; k++) begin
         tick();
         if (an1 == 4'b0111) begin
`ifdef SCORE_DISPLAY_BLINK_EN
            chk("blink_a_val", 32'(seg1 == 8'h09 || seg1 == 8'hFF), 32'd1);
`else
            chk("steady_a", 32'(seg1), 32'h09);
`endif
         end
      end

      // Randomized traffic against the model
      do_reset();
      for (int k = 0; k < 800; k++) begin
         a   = ($urandom_range(0, 2) == 0);
         b   = ($urandom_range(0, 2) == 0);
         clr = ($urandom_range(0, 59) == 0);
         rst = ($urandom_range(0, 249) == 0);
         tick();
      end
      rst = 0; a = 0; b = 0; clr = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/score_display.md
SCORE_DISPLAY -- requirements
Module: score_display

Interface
REQ-001 Parameter DIGITS, default 1, meaning BCD digits per player (1 or 2).
REQ-002 Parameter REFRESH_DIV, default 100000, meaning clk_100MHz cycles per digit slot (>=2).
REQ-003 Parameter WIN_SCORE, default 9, meaning score that ends the game (1..10^DIGITS-1).
REQ-004 Parameter BLINK_DIV, default 25000000, meaning clk_100MHz cycles per blink half-period.
REQ-005 Derived constant NAN = 2*DIGITS+2, meaning anode count.
REQ-006 Port clk_100MHz, input, 1, meaning the single system clock.
REQ-007 Port reset, input, 1, meaning synchronous active-high reset.
REQ-008 Port score_a, input, 1, meaning player point request, synchronous to clk_100MHz, counted on its rising edge.
REQ-009 Port score_b, input, 1, meaning AI point request, counted on its rising edge.
REQ-010 Port clear, input, 1, meaning synchronous score clear for a new game.
REQ-011 Port an, output, NAN, meaning active-low one-hot anode enables.
REQ-012 Port seg, output, 8, meaning active-low cathodes; seg[7:1] = A..G, seg[0] = DP.
REQ-013 Port game_over, output, 1, meaning a player has reached WIN_SCORE.
REQ-014 Port winner, output, 1, meaning 0 = A won, 1 = B won; valid only while game_over=1.

Function
REQ-015 Edge detect: each of score_a and score_b has a 1-cycle delayed copy; an event is input=1 with delayed copy=0.
REQ-016 Each score SHALL be held as DIGITS BCD digits; an event increments the score with decimal carry, and the new value is visible the cycle after the event edge.
REQ-017 Simultaneous events on score_a and score_b in the same cycle SHALL increment both scores.
REQ-018 A score SHALL saturate at WIN_SCORE and never wrap.
REQ-019 game_over SHALL assert the cycle after either score reaches WIN_SCORE, and winner SHALL be set to the player that reached it.
REQ-020 If both scores reach WIN_SCORE in the same cycle, winner SHALL be 0 (A wins ties).
REQ-021 While game_over=1, all score events SHALL be ignored.
REQ-022 clear SHALL zero both scores, game_over, winner and the edge-detector history, and SHALL take priority over a same-cycle event; it does not reset the refresh or blink counters.
REQ-023 Refresh prescaler: counts 0..REFRESH_DIV-1; on terminal count, slot index advances 0->1->...->NAN-1->0.
REQ-024 Slot mapping: slots 0..DIGITS-1 show B digits (slot 0 = least significant); slots DIGITS and DIGITS+1 show '-'; slots DIGITS+2..NAN-1 show A digits (slot NAN-1 = most significant).
REQ-025 an SHALL drive low only the bit equal to the slot index, and an and seg SHALL be registered so they change on the same edge.
REQ-026 Decode for 0-9: standard active-low patterns with DP off; '-' = 8'b11111101; blank = 8'hFF.
REQ-027 With DIGITS=2, a most-significant digit of 0 SHALL be shown blank (leading-zero suppression); with DIGITS=1 it is never blanked.

Reset
REQ-028 reset SHALL set the scores to 0, game_over=0, winner=0, edge history=0, prescaler=0, slot index=0, blink counter=0 and blink phase=on.
REQ-029 On the first cycle after reset, outputs SHALL be an = {NAN-1 ones, 0} and seg = the pattern for '0'.
REQ-030 reset asserted mid-game or mid-slot SHALL take effect on the next edge, with no partial increments.

Configuration
REQ-031 Macro SCORE_DISPLAY_BLINK_EN defined: while game_over=1, the winner's digit slots SHALL toggle between their value and blank every BLINK_DIV cycles; the loser's digits and '-' stay steady.
REQ-032 Macro SCORE_DISPLAY_BLINK_EN undefined: no blink counter is built, and all slots stay steady at all times.

Verification
REQ-033 Use DIGITS=1 and REFRESH_DIV=4; hold score_a=1 for 10 cycles -> score A = 1 only, and slot 3 shows seg 8'b10011111.
REQ-034 Send 3 pulses on score_a and 2 pulses on score_b, with one pair coincident -> A = 3, B = 2; scan order of an = 1110, 1101, 1011, 0111, each held 4 cycles.
REQ-035 Use DIGITS=2 and WIN_SCORE=12; send 12 pulses on score_b -> B = "12", game_over=1, winner=1; a 13th pulse leaves B = 12; A's tens slot is blank.
REQ-036 Pulse score_a and score_b in the same cycle when both scores are at WIN_SCORE-1 -> game_over=1 and winner=0.
REQ-037 Assert clear in the same cycle as a score_a event -> both scores are 0 and game_over=0 next cycle; assert reset mid-slot -> an = 1110 and seg = 0 pattern next cycle.
REQ-038 With SCORE_DISPLAY_BLINK_EN defined and BLINK_DIV=8 after an A win -> the A slot alternates between its digit and 8'hFF every 8 cycles; with the macro undefined it stays constant.
